ahb_image_slave: RTL and testbench
==================================

AHB_IMAGE_SLAVE -- requirements
Module: ahb_image_slave

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 6, meaning word-address width (memory depth 2**ADDR_BITS 32-bit words).
REQ-002 SHALL have parameter WAIT_STATES, default 1, legal 0..3, meaning hready-low cycles inserted at the start of each data phase.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port n_rst  input  1  synchronous, active-high reset (1 = reset on the next rising edge).
REQ-005 SHALL have port hsel  input  1  transfer request, sampled as an address phase when hsel=1 and hready=1.
REQ-006 SHALL have port haddr  input  32  byte address; the word index is haddr[ADDR_BITS+1:2].
REQ-007 SHALL have port hwrite  input  1  1 = write, 0 = read, sampled with haddr.
REQ-008 SHALL have port hwdata  input  32  write data, valid during the data phase.
REQ-009 SHALL have port hrdata  output  32  read data, valid in the final data-phase cycle.
REQ-010 SHALL have port hready  output  1  0 = stall the master, 1 = transfer completes this cycle or slave idle.
REQ-011 SHALL have port err  output  1  sticky flag for out-of-range or misaligned access.
REQ-012 SHALL have port rd_count  output  16  completed legal reads, saturating.
REQ-013 SHALL have port wr_count  output  16  completed legal writes, saturating.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT and DATA.
REQ-015 IDLE: hready=1; on an address phase, latch addr_q, write_q and legal_q, then go to WAIT if WAIT_STATES>0, else to DATA.
REQ-016 WAIT: hready=0; a down-counter loaded with WAIT_STATES-1 decrements each cycle; go to DATA when it reaches 0.
REQ-017 DATA: hready=1 for exactly one cycle, which is the final data cycle; hsel is sampled as a new address phase in the same cycle (pipelined back-to-back).
REQ-018 After DATA, go to WAIT or DATA if a new address phase was accepted, else to IDLE.
REQ-019 An access SHALL be legal when haddr[1:0]==0 and haddr[31:ADDR_BITS+2]==0.
REQ-020 A legal read SHALL drive hrdata = mem[addr_q] combinationally during DATA; hrdata SHALL be 0 in all other cycles and for illegal reads.
REQ-021 A legal write SHALL commit hwdata to mem[addr_q] at the rising edge that ends DATA; illegal writes SHALL NOT modify memory.
REQ-022 A read that immediately follows a write to the same address SHALL return the newly written value, with no stale data.
REQ-023 At the edge ending DATA, an illegal access SHALL set err=1, and err SHALL hold until reset.
REQ-024 At the edge ending DATA, a legal read SHALL increment rd_count and a legal write SHALL increment wr_count.
REQ-025 Each counter SHALL hold at 0xFFFF instead of wrapping.
REQ-026 hsel=0 cycles SHALL cause no state change except FSM progression of an already accepted transfer.
REQ-027 hsel asserted during WAIT SHALL be ignored, because hready=0; the master must hold the request until hready=1.
REQ-028 Transfer latency, address phase to completion, SHALL be WAIT_STATES+1 cycles.

Reset
REQ-029 While n_rst=1 at a rising edge:
- state SHALL go to IDLE and hready SHALL be 1;
- hrdata, err, rd_count and wr_count SHALL be 0, and the wait counter SHALL be cleared;
- all memory words SHALL be cleared to 0.
REQ-030 Reset during WAIT or DATA SHALL abort the transfer; a pending write SHALL NOT commit and counters SHALL NOT increment.
REQ-031 The first address phase SHALL be accepted in the cycle after n_rst deasserts.

Verification
REQ-032 Reset then read 0x08, WAIT_STATES=1 -> hready 0 for one cycle, then 1 with hrdata=0; rd_count=1.
REQ-033 Write 0xDEADBEEF to 0x10, then back-to-back read of 0x10 -> hrdata=0xDEADBEEF in the read's DATA cycle; wr_count=1, rd_count=1.
REQ-034 Read of 0x102 (misaligned) and write to 0x400 (out of range) -> hrdata=0, memory unchanged, err=1 persists, counters unchanged.
REQ-035 WAIT_STATES=0, continuous hsel=1 writes to 0x00, 0x04 and 0x08 -> hready stays 1, one write per cycle, wr_count=3.
REQ-036 Assert n_rst during WAIT of a write to 0x0C -> hready=1 next cycle, mem[3]=0, wr_count=0.
REQ-037 Force wr_count=0xFFFE, then perform 3 writes -> wr_count=0xFFFF and holds.

Source files
------------

// File: rtl/ahb_image_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_image_slave_if
//  Description : AHB-lite style bus bundle between a master and ahb_image_slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ahb_image_slave_if;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        err;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    modport slave (
        input  hsel, haddr, hwrite, hwdata,
        output hrdata, hready, err, rd_count, wr_count
    );

    modport master (
        output hsel, haddr, hwrite, hwdata,
        input  hrdata, hready, err, rd_count, wr_count
    );
endinterface
`default_nettype wire

// File: rtl/ahb_image_slave.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_image_slave
//  Description : Wait-stated AHB-lite memory slave with error flag and
//                saturating read/write transfer counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_image_slave #(
    parameter int ADDR_BITS   = 6,
    parameter int WAIT_STATES = 1
) (
    input  wire              clk,
    input  wire              n_rst,
    ahb_image_slave_if.slave bus
);
    localparam int         c_DEPTH     = 1 << ADDR_BITS;
    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WAIT      = 2'd1;
    localparam logic [1:0] c_DATA      = 2'd2;
    localparam logic [1:0] c_FIRST     = (WAIT_STATES > 0) ? c_WAIT : c_DATA;
    localparam logic [1:0] c_WAIT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [1:0]           r_wait_cnt;
    logic [ADDR_BITS-1:0] r_addr;
    logic                 r_write;
    logic                 r_legal;
    logic [31:0]          r_mem [c_DEPTH];
    logic                 r_err;
    logic [15:0]          r_rd_count;
    logic [15:0]          r_wr_count;
    logic                 w_hready;
    logic [31:0]          w_hrdata;
    logic                 w_accept;
    logic                 w_legal;
    logic                 w_data_phase;

    assign w_legal      = (bus.haddr[1:0] == 2'b00) && (bus.haddr[31:ADDR_BITS+2] == '0);
    assign w_accept     = bus.hsel && w_hready;
    assign w_data_phase = (r_state == c_DATA);

    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_next_state = c_FIRST;
            c_WAIT:  if (r_wait_cnt == 2'd0) w_next_state = c_DATA;
            c_DATA:  w_next_state = w_accept ? c_FIRST : c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Read data is only presented in the single completing cycle of a legal read.
    always_comb begin
        w_hready = (r_state != c_WAIT);
        w_hrdata = '0;
        if (w_data_phase && r_legal && !r_write) begin
            w_hrdata = r_mem[r_addr];
        end
    end

    // The retiring transfer and the newly accepted one share the DATA edge.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_legal    <= 1'b0;
            r_err      <= 1'b0;
            r_rd_count <= '0;
            r_wr_count <= '0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_data_phase) begin
                if (!r_legal) begin
                    r_err <= 1'b1;
                end else if (r_write) begin
                    r_mem[r_addr] <= bus.hwdata;
                    if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
                end else begin
                    if (r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
                end
            end
            if (w_accept) begin
                r_addr     <= bus.haddr[ADDR_BITS+1:2];
                r_write    <= bus.hwrite;
                r_legal    <= w_legal;
                r_wait_cnt <= c_WAIT_LOAD;
            end else if ((r_state == c_WAIT) && (r_wait_cnt != 2'd0)) begin
                r_wait_cnt <= r_wait_cnt - 2'd1;
            end
        end
    end

    assign bus.hready   = w_hready;
    assign bus.hrdata   = w_hrdata;
    assign bus.err      = r_err;
    assign bus.rd_count = r_rd_count;
    assign bus.wr_count = r_wr_count;
endmodule
`default_nettype wire

// File: tb/tb_ahb_image_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_image_slave
//  Description : Bench for ahb_image_slave (one instance with one wait state,
//                one with none) against a transfer-timeline reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_image_slave;
    localparam int WS    = 1;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic n_rst;
    logic rst0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    ahb_image_slave_if bus ();
    ahb_image_slave_if bus0 ();

    ahb_image_slave #(.ADDR_BITS(6), .WAIT_STATES(WS)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    ahb_image_slave #(.ADDR_BITS(6), .WAIT_STATES(0)) dut0 (
        .clk   (clk),
        .n_rst (rst0),
        .bus   (bus0)
    );

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a transfer accepted at the end of cycle a completes in
    // cycle a+WS+1; the slave stalls in between and is ready otherwise.
    logic [31:0] m_mem [DEPTH];
    bit          m_valid = 0;
    bit          m_err;
    int          m_rd, m_wr, cyc;
    bit          p_valid, p_wr, p_legal;
    int          p_dcyc, p_idx;

    function automatic bit m_hready();
        return !(p_valid && cyc < p_dcyc);
    endfunction

    function automatic logic [31:0] m_hrdata();
        if (p_valid && cyc == p_dcyc && p_legal && !p_wr) return m_mem[p_idx];
        return 32'h0;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("hready",   32'(bus.hready),   32'(m_hready()));
                check("hrdata",   bus.hrdata,        m_hrdata());
                check("err",      32'(bus.err),      32'(m_err));
                check("rd_count", 32'(bus.rd_count), m_rd);
                check("wr_count", 32'(bus.wr_count), m_wr);
            end
            @(posedge clk);
            if (n_rst) begin
                m_valid = 1;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
                m_err = 0; m_rd = 0; m_wr = 0; p_valid = 0; cyc = 0;
            end else begin
                bit hr;
                hr = m_hready();
                if (p_valid && cyc == p_dcyc) begin
                    if (!p_legal)   m_err = 1;
                    else if (p_wr) begin m_mem[p_idx] = bus.hwdata; if (m_wr < 65535) m_wr++; end
                    else if (m_rd < 65535) m_rd++;
                    p_valid = 0;
                end
                if (hr && bus.hsel) begin
                    p_valid = 1;
                    p_dcyc  = cyc + WS + 1;
                    p_wr    = bus.hwrite;
                    p_legal = (bus.haddr % 4 == 0) && (bus.haddr < 32'(4 * DEPTH));
                    p_idx   = int'(bus.haddr >> 2) % DEPTH;
                end
                cyc++;
            end
        end
    end

    task automatic idle(int n);
        bus.hsel = 1'b0;
        for (int k = 0; k < n; k++) begin
            bus.haddr  = $urandom;
            bus.hwrite = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    task automatic issue(logic [31:0] a, bit w, logic [31:0] d, output int stalls);
        bit acc;
        acc = 0;
        stalls = 0;
        bus.hsel = 1'b1; bus.haddr = a; bus.hwrite = w;
        for (int k = 0; k < 10 && !acc; k++) begin
            @(negedge clk);
            acc = bus.hready;
            if (!acc) stalls++;
            @(posedge clk); #1;
        end
        check("accept", 32'(acc), 32'd1);
        bus.hwdata = w ? d : $urandom;
        bus.hsel = 1'b0;
    endtask

    task automatic read_check(string nm, logic [31:0] a, logic [31:0] exp);
        bit done;
        int s, waits;
        done = 0; waits = 0;
        issue(a, 1'b0, 32'h0, s);
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge clk);
            if (bus.hready) begin
                check(nm, bus.hrdata, exp);
                done = 1;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        check({nm, "_latency"}, 32'(waits), WS);
    endtask

    task automatic lit(string nm, logic [31:0] act, logic [31:0] exp);
        @(negedge clk);
        check(nm, act, exp);
        @(posedge clk); #1;
    endtask

    task automatic ws0_cycle(bit sel, logic [31:0] a, bit w, logic [31:0] d);
        bus0.hsel = sel; bus0.haddr = a; bus0.hwrite = w; bus0.hwdata = d;
        @(negedge clk);
        check("ws0_hready", 32'(bus0.hready), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int s;
        logic [31:0] last_a, a;
        n_rst = 1'b1; rst0 = 1'b1;
        bus.hsel = 0; bus.haddr = 0; bus.hwrite = 0; bus.hwdata = 0;
        bus0.hsel = 0; bus0.haddr = 0; bus0.hwrite = 0; bus0.hwdata = 0;
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_hready", 32'(bus.hready), 32'd1);
        check("rst_hrdata", bus.hrdata, 32'h0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_counts", {bus.rd_count, bus.wr_count}, 32'h0);
        @(posedge clk); #1;

        read_check("rd08", 32'h08, 32'h0);
        lit("rd08_count", 32'(bus.rd_count), 32'd1);

        issue(32'h10, 1'b1, 32'hDEADBEEF, s);
        read_check("raw10", 32'h10, 32'hDEADBEEF);
        lit("raw_counts", {bus.rd_count, bus.wr_count}, {16'd2, 16'd1});

        read_check("misaligned", 32'h102, 32'h0);
        issue(32'h400, 1'b1, 32'h12345678, s);
        idle(2);
        lit("err_set", 32'(bus.err), 32'd1);
        read_check("oor_untouched", 32'h00, 32'h0);
        read_check("keep10", 32'h10, 32'hDEADBEEF);
        lit("err_counts", {bus.rd_count, bus.wr_count}, {16'd4, 16'd1});
        lit("err_sticky", 32'(bus.err), 32'd1);

        // Reset while the write sits in its wait state
        issue(32'h0C, 1'b1, 32'hCAFEF00D, s);
        n_rst = 1'b1;
        @(posedge clk); #1;
        n_rst = 1'b0;
        @(negedge clk);
        check("abort_hready", 32'(bus.hready), 32'd1);
        check("abort_wr", 32'(bus.wr_count), 32'd0);
        @(posedge clk); #1;
        issue(32'h0C, 1'b0, 32'h0, s);
        check("first_accept_stalls", 32'(s), 32'd0);
        idle(3);
        read_check("abort_mem3", 32'h0C, 32'h0);

        // Randomized traffic; the model compares every cycle
        last_a = 32'h0;
        for (int t = 0; t < 500; t++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 2) begin
                n_rst = 1'b1; idle(1); n_rst = 1'b0;
            end else begin
                if (sel < 30)      a = last_a;
                else if (sel < 85) a = 32'($urandom_range(0, 63)) * 4;
                else if (sel < 93) a = 32'($urandom_range(0, 1023));
                else               a = $urandom;
                issue(a, 1'($urandom_range(0, 1)), $urandom, s);
                last_a = a;
                idle(int'($urandom_range(0, 2)));
            end
        end
        idle(4);

        // Zero-wait-state instance
        rst0 = 1'b0;
        for (int k = 0; k < 3; k++) ws0_cycle(1'b1, 32'(k * 4), 1'b1, (k == 0) ? 32'h0 : 32'hA000_0000 + 32'(k - 1));
        ws0_cycle(1'b0, 32'h0, 1'b0, 32'hA000_0002);
        lit("ws0_wr3", 32'(bus0.wr_count), 32'd3);
        for (int k = 0; k < 4; k++) begin
            bus0.hsel = (k < 3); bus0.haddr = 32'(k * 4); bus0.hwrite = 1'b0;
            @(negedge clk);
            if (k > 0) check("ws0_rd", bus0.hrdata, 32'hA000_0000 + 32'(k - 1));
            @(posedge clk); #1;
        end
        ws0_cycle(1'b1, 32'h14, 1'b1, 32'h0);
        ws0_cycle(1'b1, 32'h14, 1'b0, 32'h5A5A_1234);
        bus0.hsel = 1'b0;
        lit("ws0_raw", bus0.hrdata, 32'h5A5A_1234);
        lit("ws0_counts", {bus0.rd_count, bus0.wr_count}, {16'd4, 16'd4});

        // Saturation: bring wr_count to 0xFFFE with continuous writes
        bus0.hsel = 1'b1; bus0.haddr = 32'h20; bus0.hwrite = 1'b1;
        repeat (65530) @(posedge clk);
        #1 bus0.hsel = 1'b0;
        @(posedge clk); #1;
        lit("sat_fffe", 32'(bus0.wr_count), 32'h0000FFFE);
        for (int k = 0; k < 3; k++) ws0_cycle(1'b1, 32'h24, 1'b1, 32'h0);
        ws0_cycle(1'b0, 32'h0, 1'b0, 32'h0);
        lit("sat_ffff", 32'(bus0.wr_count), 32'h0000FFFF);
        ws0_cycle(1'b1, 32'h24, 1'b1, 32'h0);
        ws0_cycle(1'b0, 32'h0, 1'b0, 32'h0);
        lit("sat_hold", 32'(bus0.wr_count), 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
